rshift_pipe8: RTL and testbench

Pipelined 8-bit right barrel shifter with valid/ready handshakes on input and output. It is the right-shift counterpart to the combinational left-shift stage chain already in the barrel shifter. It supports logical, arithmetic and rotate-right modes and uses three registered stages (shift by 4, by 2, by 1), so it sustains one operation per cycle with backpressure. It sits between an operand source and a consumer, both of which use valid/ready.

---
 rtl/rshift_pipe8_if.sv | 29 ++
 rtl/rshift_pipe8.sv | 106 ++++++++++
 tb/tb_rshift_pipe8.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rshift_pipe8_if.sv
// rshift_pipe8_if
// Handshake bundle for the pipelined 8-bit right shifter.
//   in_valid/in_ready : operand handshake (I, S, mode qualified by in_valid)
//   I                 : 8-bit data to shift
//   S                 : 3-bit right-shift amount
//   mode              : 00 logical, 01 arithmetic, 10 rotate, 11 logical
//   out_valid/out_ready : result handshake (O qualified by out_valid)
//   O                 : 8-bit shifted result
// master = operand source / result consumer side, slave = the shifter.
interface rshift_pipe8_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] I;
  logic [2:0] S;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] O;

  modport master (
    output in_valid, I, S, mode, out_ready,
    input  in_ready, out_valid, O
  );

  modport slave (
    input  in_valid, I, S, mode, out_ready,
    output in_ready, out_valid, O
  );
endinterface

// File: rtl/rshift_pipe8.sv
// rshift_pipe8
// Three-stage pipelined 8-bit right barrel shifter (shift by 4, 2, 1) with
// valid/ready on both sides. Logical, arithmetic and rotate modes; mode 11
// behaves as logical. Latency 3, throughput 1/cycle, capacity 3.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset, clears every stage
//   bus   : rshift_pipe8_if.slave (in_valid/in_ready/I/S/mode,
//           out_valid/out_ready/O)
module rshift_pipe8 (
  input  logic          clk,
  input  logic          rst_n,
  rshift_pipe8_if.slave bus
);

  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  // Stage 1: data after the shift-by-4 step, plus the two remaining shift bits
  logic       r_v1;
  logic [7:0] r_d1;
  logic [1:0] r_s1;
  logic [1:0] r_m1;
  // Stage 2: data after the shift-by-2 step, plus the last shift bit
  logic       r_v2;
  logic [7:0] r_d2;
  logic       r_s2;
  logic [1:0] r_m2;
  // Stage 3: final result
  logic       r_v3;
  logic [7:0] r_d3;

  logic       w_adv1;
  logic       w_adv2;
  logic       w_adv3;
  logic [7:0] w_sh1;
  logic [7:0] w_sh2;
  logic [7:0] w_sh3;

  // Right shift by a fixed amount k. Bits whose source index runs past bit 7
  // wrap around for rotate, copy the sign for arithmetic, and are zero
  // otherwise (which also covers the reserved mode).
  function automatic logic [7:0] shr(input logic [7:0] d, input logic [1:0] m, input int k);
    logic [7:0] r;
    int         idx;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      idx = (i + k) & 7;
      if ((i + k < 8) || (m == MODE_ROT))
        r[i] = d[idx[2:0]];
      else if (m == MODE_ARITH)
        r[i] = d[7];
      else
        r[i] = 1'b0;
    end
    return r;
  endfunction

  // Bubble-collapsing advance: a stage may load whenever it is empty or the
  // stage downstream of it is moving.
  assign w_adv3 = !r_v3 || bus.out_ready;
  assign w_adv2 = !r_v2 || w_adv3;
  assign w_adv1 = !r_v1 || w_adv2;

  assign w_sh1 = bus.S[2] ? shr(bus.I, bus.mode, 4) : bus.I;
  assign w_sh2 = r_s1[1]  ? shr(r_d1, r_m1, 2)      : r_d1;
  assign w_sh3 = r_s2     ? shr(r_d2, r_m2, 1)      : r_d2;

  // Gated by rst_n so the source never sees a grant while the pipe is held in reset
  assign bus.in_ready  = rst_n & w_adv1;
  assign bus.out_valid = r_v3;
  assign bus.O         = r_d3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
      r_s1 <= '0;
      r_m1 <= '0;
      r_v2 <= 1'b0;
      r_d2 <= '0;
      r_s2 <= 1'b0;
      r_m2 <= '0;
      r_v3 <= 1'b0;
      r_d3 <= '0;
    end else begin
      if (w_adv3) begin
        r_v3 <= r_v2;
        r_d3 <= w_sh3;
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        r_d2 <= w_sh2;
        r_s2 <= r_s1[0];
        r_m2 <= r_m1;
      end
      if (w_adv1) begin
        r_v1 <= bus.in_valid;
        r_d1 <= w_sh1;
        r_s1 <= bus.S[1:0];
        r_m1 <= bus.mode;
      end
    end
  end

endmodule

// File: tb/tb_rshift_pipe8.sv
// tb_rshift_pipe8
// Self-checking bench for rshift_pipe8: directed cases plus a randomized
// phase, checked against a scoreboard of expected results.
module tb_rshift_pipe8;

  logic clk;
  logic rst_n;

  rshift_pipe8_if bus ();

  rshift_pipe8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    int         acc;
  } item_t;

  item_t      q[$];
  int         checks_total;
  int         checks_passed;
  int         cyc;
  bit         check_lat;
  bit         in_fire;
  bit         out_fire;
  logic [7:0] drv_exp;

  // Reference: whole-word arithmetic on the operand
  function automatic logic [7:0] ref_shift(input logic [7:0] i, input logic [2:0] s,
                                           input logic [1:0] m);
    logic [15:0] w;
    case (m)
      2'b01:   return 8'($signed(i) >>> s);
      2'b10: begin
        w = {i, i} >> s;
        return w[7:0];
      end
      default: return i >> s;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks_total++;
    assert (obs === expv) checks_passed++;
    else $error("FAIL %s: observed %02h expected %02h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  // One clock cycle: sample at the falling edge, update scoreboard, then
  // return 1 time unit after the rising edge so the caller can drive inputs.
  task automatic cycle();
    logic exp_ov;
    @(negedge clk);
    chk("in_ready", 8'(bus.in_ready), 8'((q.size() < 3) || bus.out_ready));
    if (check_lat) begin
      exp_ov = (q.size() > 0) && (q[0].acc + 3 == cyc);
      chk("out_valid", 8'(bus.out_valid), 8'(exp_ov));
    end
    if (bus.out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", 8'(bus.out_valid), 8'd0);
      else               chk("O", bus.O, q[0].res);
    end
    out_fire = bus.out_valid && bus.out_ready;
    in_fire  = bus.in_valid && bus.in_ready;
    if (out_fire) begin
      $display("cyc %0d out O=%02h", cyc, bus.O);
      if (q.size() > 0) void'(q.pop_front());
    end
    if (in_fire) begin
      $display("cyc %0d in  I=%02h S=%0d mode=%0d exp=%02h", cyc, bus.I, bus.S, bus.mode, drv_exp);
      q.push_back('{res: drv_exp, acc: cyc});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [7:0] i, input logic [2:0] s, input logic [1:0] m,
                      input logic [7:0] e);
    bus.in_valid = 1'b1;
    bus.I        = i;
    bus.S        = s;
    bus.mode     = m;
    drv_exp      = e;
    for (int t = 0; t < 50; t++) begin
      cycle();
      if (in_fire) break;
    end
    chk("send_accepted", 8'(in_fire), 8'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    cycle();
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && q.size() > 0; t++) cycle();
    chk("drained", 8'(q.size()), 8'd0);
  endtask

  initial begin
    logic [7:0] sweep_exp [8];
    logic [7:0] bp_exp [5];
    int         idx;

    sweep_exp = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
    bp_exp    = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8};

    checks_total  = 0;
    checks_passed = 0;
    cyc           = 0;
    check_lat     = 1'b0;
    drv_exp       = '0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.I         = '0;
    bus.S         = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_O", bus.O, 8'h00);
    chk("rst_in_ready", 8'(bus.in_ready), 8'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three modes on the same operand, latency checked
    check_lat     = 1'b1;
    bus.out_ready = 1'b1;
    send(8'hB2, 3'd3, 2'b00, 8'h16);
    send(8'hB2, 3'd3, 2'b01, 8'hF6);
    send(8'hB2, 3'd3, 2'b10, 8'h56);
    drain();

    // Rotate sweep, back to back
    for (int s = 0; s < 8; s++) send(8'h81, 3'(s), 2'b10, sweep_exp[s]);
    drain();

    // Bubbles, including reserved mode
    send(8'hF0, 3'd4, 2'b11, 8'h0F);
    idle();
    send(8'hA5, 3'd1, 2'b10, 8'hD2);
    idle();
    drain();

    // Backpressure: consumer stalls for the first 6 cycles
    check_lat = 1'b0;
    idx       = 0;
    for (int k = 0; k < 40 && (idx < 5 || q.size() > 0); k++) begin
      bus.out_ready = (k >= 6);
      bus.in_valid  = (idx < 5);
      if (idx < 5) begin
        bus.I    = 8'h80;
        bus.S    = 3'(idx);
        bus.mode = 2'b01;
        drv_exp  = bp_exp[idx];
      end
      cycle();
      if (in_fire) idx++;
      if (k == 5) chk("bp_accepts_during_stall", 8'(idx), 8'd3);
    end
    chk("bp_all_accepted", 8'(idx), 8'd5);
    drain();

    // Reset with three operations in flight
    bus.out_ready = 1'b0;
    send(8'h11, 3'd1, 2'b00, 8'h08);
    send(8'h22, 3'd2, 2'b01, 8'h08);
    send(8'h33, 3'd3, 2'b10, 8'h66);
    bus.in_valid = 1'b0;
    chk("pre_rst_out_valid", 8'(bus.out_valid), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 8'(bus.out_valid), 8'd0);
    chk("midrst_O", bus.O, 8'h00);
    chk("midrst_in_ready", 8'(bus.in_ready), 8'd0);
    q.delete();
    #2 rst_n = 1'b1;
    check_lat     = 1'b1;
    bus.out_ready = 1'b1;
    send(8'h01, 3'd0, 2'b00, 8'h01);
    drain();

    // Randomized traffic with random backpressure
    check_lat = 1'b0;
    for (int k = 0; k < 300; k++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.I         = 8'($urandom);
      bus.S         = 3'($urandom);
      bus.mode      = 2'($urandom);
      drv_exp       = ref_shift(bus.I, bus.S, bus.mode);
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
